// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for a streaming FFT core: flushes the core, captures one frame of ADC
// samples, waits for the transform, then reads magnitude bins out under a valid/accept handshake.
module fft_frame_sequencer #(
  parameter int FFT_LENGTH   = 1024,
  parameter int NUM_BINS     = FFT_LENGTH / 2,
  parameter int FLUSH_CYCLES = 4,
  parameter int TIMEOUT      = 65535,
  localparam int IDX_W       = $clog2(FFT_LENGTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             adc_valid_i,
  input  logic [11:0]      adc_data_i,
  input  logic             fft_done_i,
  input  logic [15:0]      mag_i,
  input  logic             mag_ready_i,
  input  logic             mag_accept_i,
  output logic             fft_reset_o,
  output logic             fft_in_valid_o,
  output logic [15:0]      fft_in_real_o,
  output logic [IDX_W-1:0] index_o,
  output logic [15:0]      mag_o,
  output logic             mag_valid_o,
  output logic             frame_done_o,
  output logic             busy_o,
  output logic             overrun_o,
  output logic             timeout_o
);

  localparam int FL_W = $clog2(FLUSH_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, FLUSH, CAPTURE, COMPUTE, READ_REQ, READ_HOLD, DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] sample_cnt;
  logic [FL_W-1:0]  flush_cnt;
  logic [TO_W-1:0]  tout_cnt;
  logic             drop_window;

  // Unsigned 12-bit ADC code placed in the top of the 16-bit FFT input word.
  function automatic logic [15:0] widen_sample(input logic [11:0] s);
    return {s, 4'b0000};
  endfunction

  assign drop_window = (state == COMPUTE) || (state == READ_REQ) ||
                       (state == READ_HOLD) || (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      fft_reset_o    <= 1'b1;
      busy_o         <= 1'b0;
      fft_in_valid_o <= 1'b0;
      fft_in_real_o  <= '0;
      index_o        <= '0;
      mag_o          <= '0;
      mag_valid_o    <= 1'b0;
      frame_done_o   <= 1'b0;
      overrun_o      <= 1'b0;
      timeout_o      <= 1'b0;
      sample_cnt     <= '0;
      flush_cnt      <= '0;
      tout_cnt       <= '0;
    end else begin
      fft_in_valid_o <= 1'b0;
      frame_done_o   <= 1'b0;
      if (adc_valid_i && drop_window) overrun_o <= 1'b1;

      case (state)
        IDLE: begin
          if (enable) begin
            state      <= FLUSH;
            busy_o     <= 1'b1;
            flush_cnt  <= '0;
            sample_cnt <= '0;
          end
        end

        FLUSH: begin
          if (flush_cnt == FL_W'(FLUSH_CYCLES - 1)) begin
            state       <= CAPTURE;
            fft_reset_o <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end

        // Capture stage: one registered FFT input word per strobe
        CAPTURE: begin
          if (adc_valid_i) begin
            fft_in_real_o  <= widen_sample(adc_data_i);
            fft_in_valid_o <= 1'b1;
            if (sample_cnt == IDX_W'(FFT_LENGTH - 1)) begin
              state    <= COMPUTE;
              tout_cnt <= '0;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end

        // A timed-out transform aborts the frame without a done pulse
        COMPUTE: begin
          if (fft_done_i) begin
            state   <= READ_REQ;
            index_o <= '0;
          end else if (tout_cnt == TO_W'(TIMEOUT - 1)) begin
            state       <= IDLE;
            timeout_o   <= 1'b1;
            fft_reset_o <= 1'b1;
            busy_o      <= 1'b0;
          end else begin
            tout_cnt <= tout_cnt + 1'b1;
          end
        end

        // Readout stage: request a bin, then hold it until downstream takes it
        READ_REQ: begin
          if (mag_ready_i) begin
            mag_o       <= mag_i;
            mag_valid_o <= 1'b1;
            state       <= READ_HOLD;
          end
        end

        READ_HOLD: begin
          if (mag_accept_i) begin
            mag_valid_o <= 1'b0;
            if (index_o == IDX_W'(NUM_BINS - 1)) begin
              state        <= DONE;
              frame_done_o <= 1'b1;
            end else begin
              index_o <= index_o + 1'b1;
              state   <= READ_REQ;
            end
          end
        end

        DONE: begin
          fft_reset_o <= 1'b1;
          flush_cnt   <= '0;
          sample_cnt  <= '0;
          if (enable) begin
            state <= FLUSH;
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed-sequence bench for fft_frame_sequencer: five frames covering normal capture/readout,
// backpressure, overrun, FFT timeout and mid-frame reset, checked against a queue-based model.
module tb_fft_frame_sequencer;

  localparam int FFT_LENGTH   = 1024;
  localparam int NUM_BINS     = 512;
  localparam int FLUSH_CYCLES = 4;
  localparam int TIMEOUT      = 100;
  localparam int IDX_W        = 10;

  logic             clk = 1'b0;
  logic             reset, enable, adc_valid_i, fft_done_i, mag_ready_i, mag_accept_i;
  logic [11:0]      adc_data_i;
  logic [15:0]      mag_i;
  logic             fft_reset_o, fft_in_valid_o, mag_valid_o, frame_done_o;
  logic             busy_o, overrun_o, timeout_o;
  logic [15:0]      fft_in_real_o, mag_o;
  logic [IDX_W-1:0] index_o;

  int checks = 0;
  int errors = 0;
  logic [15:0] salt;
  logic [15:0] exp_samples[$];
  logic [15:0] got_samples[$];
  logic [15:0] got_mags[$];
  int          got_idx[$];
  int frame_done_cnt = 0;
  int fast_beats = 0;
  int cyc = 0;
  int last_beat = -10;

  fft_frame_sequencer #(
    .FFT_LENGTH(FFT_LENGTH), .NUM_BINS(NUM_BINS),
    .FLUSH_CYCLES(FLUSH_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .adc_valid_i(adc_valid_i),
    .adc_data_i(adc_data_i), .fft_done_i(fft_done_i), .mag_i(mag_i),
    .mag_ready_i(mag_ready_i), .mag_accept_i(mag_accept_i),
    .fft_reset_o(fft_reset_o), .fft_in_valid_o(fft_in_valid_o),
    .fft_in_real_o(fft_in_real_o), .index_o(index_o), .mag_o(mag_o),
    .mag_valid_o(mag_valid_o), .frame_done_o(frame_done_o), .busy_o(busy_o),
    .overrun_o(overrun_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // FFT core stand-in: bin magnitude is a salted index, garbage while not ready
  always_comb mag_i = mag_ready_i ? (16'(index_o) ^ salt) : 16'hDEAD;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      if (fft_in_valid_o) got_samples.push_back(fft_in_real_o);
      if (mag_valid_o && mag_accept_i) begin
        got_mags.push_back(mag_o);
        got_idx.push_back(int'(index_o));
        if (cyc - last_beat < 2) fast_beats <= fast_beats + 1;
        last_beat <= cyc;
      end
      if (frame_done_o) frame_done_cnt <= frame_done_cnt + 1;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [11:0] d, input bit in_frame);
    adc_data_i  = d;
    adc_valid_i = 1'b1;
    tick;
    adc_valid_i = 1'b0;
    if (in_frame) exp_samples.push_back({d, 4'b0000});
  endtask

  task automatic clear_frame;
    exp_samples.delete();
    got_samples.delete();
    got_mags.delete();
    got_idx.delete();
  endtask

  task automatic check_reset_values(input string p);
    chk({p, "_fft_reset"}, fft_reset_o, 1);
    chk({p, "_in_valid"}, fft_in_valid_o, 0);
    chk({p, "_in_real"}, fft_in_real_o, 0);
    chk({p, "_index"}, index_o, 0);
    chk({p, "_mag"}, mag_o, 0);
    chk({p, "_mag_valid"}, mag_valid_o, 0);
    chk({p, "_frame_done"}, frame_done_o, 0);
    chk({p, "_overrun"}, overrun_o, 0);
    chk({p, "_timeout"}, timeout_o, 0);
    chk({p, "_busy"}, busy_o, 0);
  endtask

  task automatic wait_flush(output int n);
    n = 0;
    while (fft_reset_o && n < 64) begin
      tick;
      n++;
    end
  endtask

  task automatic fft_pulse;
    fft_done_i = 1'b1;
    tick;
    fft_done_i = 1'b0;
    chk("read_index0", index_o, 0);
    chk("read_busy", busy_o, 1);
  endtask

  // mode 0: ready/accept tied high; 1: random handshakes; 2: random plus 10-cycle stall at bin 5
  task automatic readout(input int mode, output int stall);
    int n = 0;
    stall = 0;
    while (!frame_done_o && n < 8 * NUM_BINS + 200) begin
      if (mode == 0) begin
        mag_ready_i  = 1'b1;
        mag_accept_i = 1'b1;
      end else begin
        mag_ready_i  = ($urandom_range(0, 3) != 0);
        mag_accept_i = ($urandom_range(0, 2) != 0);
        if (mode == 2 && mag_valid_o && index_o == 5) begin
          if (stall < 10) begin
            mag_accept_i = 1'b0;
            chk("stall_mag", mag_o, 16'(5) ^ salt);
            chk("stall_valid", mag_valid_o, 1);
            chk("stall_index", index_o, 5);
            stall++;
          end else begin
            mag_accept_i = 1'b1;
          end
        end
      end
      tick;
      n++;
    end
    chk("frame_done_seen", frame_done_o, 1);
    mag_ready_i  = 1'b0;
    mag_accept_i = 1'b0;
  endtask

  task automatic verify_frame;
    int bad = 0;
    chk("sample_count", got_samples.size(), FFT_LENGTH);
    for (int i = 0; i < got_samples.size() && i < exp_samples.size(); i++)
      if (got_samples[i] !== exp_samples[i]) bad++;
    chk("sample_data", bad, 0);
    chk("bin_count", got_mags.size(), NUM_BINS);
    bad = 0;
    for (int i = 0; i < got_mags.size(); i++)
      if (got_mags[i] !== (16'(i) ^ salt) || got_idx[i] != i) bad++;
    chk("bin_data", bad, 0);
    chk("beat_rate", fast_beats, 0);
  endtask

  initial begin
    int n;
    int st;
    reset = 1'b1; enable = 1'b0; adc_valid_i = 1'b0; adc_data_i = '0;
    fft_done_i = 1'b0; mag_ready_i = 1'b0; mag_accept_i = 1'b0; salt = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    @(negedge clk) reset = 1'b0;
    tick;
    chk("idle_busy", busy_o, 0);

    // Frame 1: slow strobes, data = k, mag = index, accept tied high
    enable = 1'b1;
    wait_flush(n);
    chk("flush_len_idle", n, FLUSH_CYCLES + 1);
    clear_frame();
    for (int k = 0; k < FFT_LENGTH; k++) begin
      strobe(12'(k), 1'b1);
      if (k < FFT_LENGTH - 1) repeat (20) tick;
    end
    chk("compute_busy", busy_o, 1);
    repeat (3) tick;
    fft_pulse();
    readout(0, st);
    tick;
    chk("flush_after_done", fft_reset_o, 1);
    chk("busy_after_done", busy_o, 1);
    wait_flush(n);
    chk("flush_len_between", n, FLUSH_CYCLES);
    verify_frame();
    chk("frame_done_cnt1", frame_done_cnt, 1);

    // Frame 2: random data and handshakes, overrun strobe, backpressure at bin 5
    clear_frame();
    salt = 16'($urandom);
    for (int k = 0; k < FFT_LENGTH; k++) begin
      strobe(12'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) tick;
    end
    chk("overrun_pre", overrun_o, 0);
    strobe(12'($urandom), 1'b0);
    chk("overrun_set", overrun_o, 1);
    repeat (2) tick;
    chk("overrun_sticky", overrun_o, 1);
    fft_pulse();
    readout(2, st);
    chk("stall_cycles", st, 10);
    tick;
    chk("flush_after_done2", fft_reset_o, 1);
    verify_frame();
    chk("frame_done_cnt2", frame_done_cnt, 2);
    chk("overrun_kept", overrun_o, 1);

    // Frame 3: enable dropped mid-capture, FFT never finishes
    wait_flush(n);
    chk("flush_len_between2", n, FLUSH_CYCLES);
    clear_frame();
    for (int k = 0; k < FFT_LENGTH; k++) begin
      if (k == 10) enable = 1'b0;
      strobe(12'($urandom), 1'b1);
    end
    repeat (TIMEOUT - 1) tick;
    chk("timeout_early", timeout_o, 0);
    chk("timeout_early_busy", busy_o, 1);
    tick;
    chk("timeout_set", timeout_o, 1);
    chk("timeout_idle", busy_o, 0);
    chk("timeout_fft_reset", fft_reset_o, 1);
    repeat (5) tick;
    chk("timeout_stays_idle", busy_o, 0);
    chk("timeout_sticky", timeout_o, 1);
    chk("timeout_no_done", frame_done_cnt, 2);
    chk("timeout_samples", got_samples.size(), FFT_LENGTH);

    // Frame 4: reset after sample 300
    enable = 1'b1;
    wait_flush(n);
    chk("flush_len_idle2", n, FLUSH_CYCLES + 1);
    clear_frame();
    for (int k = 0; k < 300; k++)
      strobe((k == 299) ? 12'hABC : 12'($urandom), 1'b1);
    chk("pre_abort_valid", fft_in_valid_o, 1);
    chk("pre_abort_real", fft_in_real_o, 16'hABC0);
    #1 reset = 1'b1;
    #1;
    check_reset_values("abort");
    @(negedge clk) reset = 1'b0;

    // Frame 5: must need a full frame of samples after the abort
    wait_flush(n);
    chk("flush_len_after_abort", n, FLUSH_CYCLES + 1);
    chk("abort_no_done", frame_done_cnt, 2);
    clear_frame();
    salt = 16'($urandom);
    for (int k = 0; k < FFT_LENGTH - 1; k++) begin
      strobe(12'($urandom), 1'b1);
      repeat ($urandom_range(0, 1)) tick;
    end
    repeat (3) tick;
    chk("partial_count", got_samples.size(), FFT_LENGTH - 1);
    chk("partial_overrun", overrun_o, 0);
    chk("partial_busy", busy_o, 1);
    strobe(12'($urandom), 1'b1);
    fft_pulse();
    readout(1, st);
    tick;
    verify_frame();
    chk("frame_done_cnt3", frame_done_cnt, 3);
    chk("final_timeout_clear", timeout_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_sequencer.md
FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 SHALL have parameter FFT_LENGTH, default 1024, points per FFT frame.
REQ-002 SHALL have parameter NUM_BINS, default FFT_LENGTH/2, magnitude bins read out per frame (real input gives a mirrored spectrum).
REQ-003 SHALL have parameter FLUSH_CYCLES, default 4, cycles the FFT reset is held before each frame.
REQ-004 SHALL have parameter TIMEOUT, default 65535, maximum cycles waited for FFT completion.
REQ-005 SHALL have ports clk in 1 (system clock) and reset in 1 (asynchronous, active-high).
REQ-006 SHALL have ports enable in 1 (run frames continuously) and adc_valid_i in 1 (one-cycle sample strobe).
REQ-007 SHALL have ports adc_data_i in 12 (unsigned ADC sample) and fft_done_i in 1 (FFT core done).
REQ-008 SHALL have ports mag_i in 16 (FFT magnitude for index_o) and mag_ready_i in 1 (mag_i valid for current index_o).
REQ-009 SHALL have port mag_accept_i in 1 (downstream consumed mag_o).
REQ-010 SHALL have ports fft_reset_o out 1 (FFT core reset) and fft_in_valid_o out 1 (FFT input stream active).
REQ-011 SHALL have ports fft_in_real_o out 16 (FFT real input) and index_o out log2(FFT_LENGTH) (FFT readout index).
REQ-012 SHALL have ports mag_o out 16 (held magnitude) and mag_valid_o out 1 (mag_o valid).
REQ-013 SHALL have ports frame_done_o out 1 (one-cycle pulse), busy_o out 1 (not IDLE), overrun_o out 1 (sticky dropped sample) and timeout_o out 1 (sticky FFT timeout).

Function
REQ-014 SHALL implement states IDLE, FLUSH, CAPTURE, COMPUTE, READ_REQ, READ_HOLD, DONE.
REQ-015 SHALL hold fft_reset_o = 1 in IDLE and FLUSH and 0 in all other states.
REQ-016 SHALL leave IDLE for FLUSH when enable = 1, and leave FLUSH for CAPTURE after exactly FLUSH_CYCLES cycles.
REQ-017 SHALL in CAPTURE register each adc_valid_i sample as fft_in_real_o = {adc_data_i, 4'b0000} with fft_in_valid_o = 1 one cycle later, for exactly one cycle per sample.
REQ-018 SHALL count accepted samples and enter COMPUTE on the cycle after the FFT_LENGTH-th sample is registered; further adc_valid_i SHALL NOT produce fft_in_valid_o.
REQ-019 SHALL set overrun_o when adc_valid_i = 1 in COMPUTE, READ_REQ, READ_HOLD or DONE, and drop that sample.
REQ-020 SHALL in COMPUTE go to READ_REQ with index_o = 0 when fft_done_i = 1.
REQ-021 SHALL in COMPUTE go to IDLE, set timeout_o, and suppress frame_done_o when TIMEOUT cycles elapse without fft_done_i.
REQ-022 SHALL in READ_REQ drive index_o stable, and on mag_ready_i = 1 latch mag_i into mag_o, set mag_valid_o the next cycle and enter READ_HOLD.
REQ-023 SHALL in READ_HOLD hold mag_o and mag_valid_o unchanged until mag_accept_i = 1.
REQ-024 SHALL on mag_valid_o & mag_accept_i clear mag_valid_o that cycle, then enter DONE if index_o = NUM_BINS-1, else increment index_o and enter READ_REQ.
REQ-025 SHALL sustain at most one bin per 2 cycles, with no bin skipped or repeated.
REQ-026 SHALL in DONE pulse frame_done_o for one cycle and go to FLUSH if enable = 1, else IDLE.
REQ-027 SHALL sample enable only in IDLE and DONE; deasserting enable mid-frame SHALL complete the current frame.
REQ-028 SHALL drive busy_o = 1 in every state except IDLE.

Reset
REQ-029 SHALL on reset = 1 asynchronously enter IDLE with fft_reset_o = 1, fft_in_valid_o = 0, fft_in_real_o = 0, index_o = 0, mag_o = 0, mag_valid_o = 0, frame_done_o = 0, overrun_o = 0, timeout_o = 0, and clear sample and timeout counters.
REQ-030 SHALL treat reset mid-frame as an abort: no frame_done_o, and the next frame restarts from FLUSH with a zeroed sample count.

Verification
REQ-031 SHALL pass this scenario: enable = 1, 1024 strobes (1 every 21 cycles, data = k), fft_done_i after 1024 strobes, mag_i = index, mag_accept_i tied 1 -> exactly 1024 fft_in_valid_o pulses with fft_in_real_o = k<<4, 512 mag_valid_o beats with mag_o = 0..511, one frame_done_o.
REQ-032 SHALL pass this scenario: mag_accept_i low for 10 cycles at bin 5 -> mag_o = 5 and mag_valid_o held for all 10 cycles, index_o stays 5, then bin 6 follows.
REQ-033 SHALL pass this scenario: 1025th strobe during COMPUTE -> overrun_o = 1 and sticky, no fft_in_valid_o pulse.
REQ-034 SHALL pass this scenario: TIMEOUT = 100, fft_done_i never asserted -> timeout_o = 1 at cycle 100 of COMPUTE, IDLE, frame_done_o never pulses.
REQ-035 SHALL pass this scenario: reset asserted after sample 300 -> all outputs at reset values immediately, and the next frame needs a full 1024 samples.
REQ-036 SHALL pass this scenario: enable = 1 continuously -> FLUSH re-entered the cycle after frame_done_o, with fft_reset_o high for 4 cycles between frames.
